// File: rtl/alu_pkg.sv
// Shared types and constants for the SimpleRISC execute-stage ALU.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } alu_state_e;

  typedef enum logic [3:0] {
    OpNone,
    OpMul,
    OpDiv,
    OpMod,
    OpAdd,
    OpSub,
    OpCmp,
    OpAnd,
    OpOr,
    OpNot,
    OpMov,
    OpLsl,
    OpLsr,
    OpAsr
  } alu_op_e;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_mod;
    logic is_add;
    logic is_sub;
    logic is_cmp;
    logic is_and;
    logic is_or;
    logic is_not;
    logic is_mov;
    logic is_lsl;
    logic is_lsr;
    logic is_asr;
  } alu_flags_t;

  // First set flag wins; the control unit may raise several at once.
  function automatic alu_op_e prio_encode(alu_flags_t f);
    alu_op_e op;
    if (f.is_mul)      op = OpMul;
    else if (f.is_div) op = OpDiv;
    else if (f.is_mod) op = OpMod;
    else if (f.is_add) op = OpAdd;
    else if (f.is_sub) op = OpSub;
    else if (f.is_cmp) op = OpCmp;
    else if (f.is_and) op = OpAnd;
    else if (f.is_or)  op = OpOr;
    else if (f.is_not) op = OpNot;
    else if (f.is_mov) op = OpMov;
    else if (f.is_lsl) op = OpLsl;
    else if (f.is_lsr) op = OpLsr;
    else if (f.is_asr) op = OpAsr;
    else               op = OpNone;
    return op;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/ex_alu_seq_if.sv
// Control-unit / operand-fetch facing bundle of the execute-stage ALU.
interface ex_alu_seq_if
  import alu_pkg::*;
();
  logic            start;
  logic            flush;
  logic            isAdd, isSub, isCmp, isMul, isDiv, isMod;
  logic            isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            flag_e;
  logic            flag_gt;

  modport master (
    output start, flush, op_a, op_b,
    output isAdd, isSub, isCmp, isMul, isDiv, isMod,
    output isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov,
    input  busy, done, result, flag_e, flag_gt
  );

  modport slave (
    input  start, flush, op_a, op_b,
    input  isAdd, isSub, isCmp, isMul, isDiv, isMod,
    input  isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov,
    output busy, done, result, flag_e, flag_gt
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative signed mul/div/mod engine: shift-add multiplier and restoring divider
// working on magnitudes, sign applied in the fix-up cycle.
module seq_muldiv
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  alu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic            neg_q, neg_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] x_q, x_d;  // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] y_q, y_d;  // multiplier, or divisor
  logic [XLEN:0]   acc_q, acc_d;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    a_d      = a_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    done_o   = 1'b0;
    rem_sh   = {acc_q[XLEN-1:0], x_q[XLEN-1]};

    mag      = (op_q == OpDiv) ? x_q : acc_q[XLEN-1:0];
    result_o = neg_q ? -mag : mag;
    if (div0_q) begin
      if (op_q == OpDiv)      result_o = DIV0_QUOT;
      else if (op_q == OpMod) result_o = a_q;
    end

    case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          a_d     = a_i;
          x_d     = abs_val(a_i);
          y_d     = abs_val(b_i);
          acc_d   = '0;
          cnt_d   = CntLast;
          div0_d  = (b_i == '0);
          neg_d   = (op_i == OpMod) ? a_i[XLEN-1] : (a_i[XLEN-1] ^ b_i[XLEN-1]);
          state_d = StIter;
        end
      end
      StIter: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (op_q == OpMul) begin
            if (y_q[0]) acc_d = acc_q + {1'b0, x_q};
            x_d = x_q << 1;
            y_d = y_q >> 1;
          end else if (rem_sh >= {1'b0, y_q}) begin
            acc_d = rem_sh - {1'b0, y_q};
            x_d   = {x_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            x_d   = {x_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StFix;
        end
      end
      StFix: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNone;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/ex_alu_seq.sv
// Execute-stage ALU: single-cycle datapath plus a stalling mul/div/mod engine,
// with registered result and compare flags.
module ex_alu_seq
  import alu_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  ex_alu_seq_if.slave alu
);

  localparam int unsigned ShW = $clog2(XLEN);

  alu_flags_t      flags;
  alu_op_e         op_sel;
  logic            is_md;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] sc_res;

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            fgt_q, fgt_d;

  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign flags = '{
    is_mul: alu.isMul, is_div: alu.isDiv, is_mod: alu.isMod, is_add: alu.isAdd,
    is_sub: alu.isSub, is_cmp: alu.isCmp, is_and: alu.isAnd, is_or:  alu.isOr,
    is_not: alu.isNot, is_mov: alu.isMov, is_lsl: alu.isLsl, is_lsr: alu.isLsr,
    is_asr: alu.isAsr
  };

  assign op_sel = prio_encode(flags);
  assign is_md  = (op_sel == OpMul) || (op_sel == OpDiv) || (op_sel == OpMod);
  assign shamt  = alu.op_b[ShW-1:0];

  always_comb begin
    sc_res = '0;
    case (op_sel)
      OpAdd:        sc_res = alu.op_a + alu.op_b;
      OpSub, OpCmp: sc_res = alu.op_a - alu.op_b;
      OpAnd:        sc_res = alu.op_a & alu.op_b;
      OpOr:         sc_res = alu.op_a | alu.op_b;
      OpNot:        sc_res = ~alu.op_b;
      OpMov:        sc_res = alu.op_b;
      OpLsl:        sc_res = alu.op_a << shamt;
      OpLsr:        sc_res = alu.op_a >> shamt;
      OpAsr:        sc_res = $signed(alu.op_a) >>> shamt;
      default:      sc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    fe_d     = fe_q;
    fgt_d    = fgt_q;
    md_start = 1'b0;
    case (state_q)
      StIdle: begin
        // flush beats start: nothing is accepted in that cycle
        if (alu.start && !alu.flush) begin
          if (is_md) begin
            md_start = 1'b1;
            state_d  = StIter;
          end else begin
            result_d = sc_res;
            done_d   = 1'b1;
            if (op_sel == OpCmp) begin
              fe_d  = (alu.op_a == alu.op_b);
              fgt_d = ($signed(alu.op_a) > $signed(alu.op_b));
            end
          end
        end
      end
      StIter: begin
        if (alu.flush) begin
          state_d = StIdle;
        end else if (md_done) begin
          result_d = md_result;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      done_q   <= 1'b0;
      fe_q     <= 1'b0;
      fgt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      fe_q     <= fe_d;
      fgt_q    <= fgt_d;
    end
  end

  seq_muldiv u_muldiv (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (md_start),
    .flush_i  (alu.flush),
    .op_i     (op_sel),
    .a_i      (alu.op_a),
    .b_i      (alu.op_b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign alu.busy    = (state_q == StIter);
  assign alu.done    = done_q;
  assign alu.result  = result_q;
  assign alu.flag_e  = fe_q;
  assign alu.flag_gt = fgt_q;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Bench for ex_alu_seq: directed corner cases plus random traffic against a
// latency-counting reference model evaluated on every cycle.
module tb_ex_alu_seq;
  import alu_pkg::*;

  // Flag bit positions in priority order (bit 0 wins).
  localparam int FMul = 0, FDiv = 1, FMod = 2, FAdd = 3, FSub = 4, FCmp = 5, FAnd = 6;
  localparam int FOr = 7, FNot = 8, FMov = 9, FLsl = 10, FLsr = 11, FAsr = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] fl;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ex_alu_seq_if bus ();

  ex_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (bus)
  );

  assign bus.isMul = fl[FMul];
  assign bus.isDiv = fl[FDiv];
  assign bus.isMod = fl[FMod];
  assign bus.isAdd = fl[FAdd];
  assign bus.isSub = fl[FSub];
  assign bus.isCmp = fl[FCmp];
  assign bus.isAnd = fl[FAnd];
  assign bus.isOr  = fl[FOr];
  assign bus.isNot = fl[FNot];
  assign bus.isMov = fl[FMov];
  assign bus.isLsl = fl[FLsl];
  assign bus.isLsr = fl[FLsr];
  assign bus.isAsr = fl[FAsr];

  typedef struct packed {
    logic [7:0]  remain;  // cycles until a pending mul/div/mod result lands
    logic [31:0] pend;
    logic [31:0] res;
    logic        done;
    logic        fe;
    logic        fgt;
  } mdl_t;

  mdl_t m;

  function automatic int first_set(logic [12:0] f);
    for (int i = 0; i < 13; i++) if (f[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] ref_result(int idx, logic [31:0] a, logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    longint    p;
    logic [4:0] sh = b[4:0];
    case (idx)
      FMul: begin
        p = longint'(sa) * longint'(sb);
        return p[31:0];
      end
      FDiv: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      FMod: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      FAdd:       return a + b;
      FSub, FCmp: return a - b;
      FAnd:       return a & b;
      FOr:        return a | b;
      FNot:       return ~b;
      FMov:       return b;
      FLsl:       return a << sh;
      FLsr:       return a >> sh;
      FAsr:       return sa >>> sh;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic mdl_t model_step(mdl_t cur, logic st, logic fs, logic [12:0] f,
                                      logic [31:0] a, logic [31:0] b);
    mdl_t n = cur;
    int   idx;
    n.done = 1'b0;
    if (cur.remain != 0) begin
      if (fs) begin
        n.remain = 0;
      end else begin
        n.remain = cur.remain - 8'd1;
        if (n.remain == 0) begin
          n.res  = cur.pend;
          n.done = 1'b1;
        end
      end
    end else if (st && !fs) begin
      idx = first_set(f);
      if (idx >= FMul && idx <= FMod) begin
        n.remain = 8'd33;
        n.pend   = ref_result(idx, a, b);
      end else begin
        n.res  = ref_result(idx, a, b);
        n.done = 1'b1;
        if (idx == FCmp) begin
          n.fe  = (a == b);
          n.fgt = ($signed(a) > $signed(b));
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, bus.start, bus.flush, fl, bus.op_a, bus.op_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",    32'(bus.busy),    32'(m.remain != 0));
      check("done",    32'(bus.done),    32'(m.done));
      check("result",  bus.result,       m.res);
      check("flag_e",  32'(bus.flag_e),  32'(m.fe));
      check("flag_gt", 32'(bus.flag_gt), 32'(m.fgt));
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int f, input logic [31:0] a, input logic [31:0] b);
    fl = '0;
    fl[f] = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fl        = '0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 0; k < 100 && !bus.done; k++) begin
      if (bus.busy) cyc++;
      @(negedge clk);
    end
    check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [12:0] rand_flags();
    logic [12:0] f = '0;
    case ($urandom % 8)
      0:       f = '0;
      1:       f = 13'($urandom);
      default: f[$urandom % 13] = 1'b1;
    endcase
    return f;
  endfunction

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    fl        = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'h0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(FAdd, 32'd7, -32'sd3);
    check("add_done", 32'(bus.done), 32'd1);
    check("add_res",  bus.result, 32'd4);
    check("add_busy", 32'(bus.busy), 32'd0);

    issue(FCmp, 32'd5, 32'd5);
    check("cmp_fe",  32'(bus.flag_e),  32'd1);
    check("cmp_fgt", 32'(bus.flag_gt), 32'd0);
    check("cmp_res", bus.result, 32'd0);

    issue(FMul, -32'sd6, 32'd7);
    wait_done(cyc);
    check("mul_lat", 32'(cyc), 32'd33);
    check("mul_res", bus.result, 32'hFFFF_FFD6);

    issue(FDiv, -32'sd7, 32'd2);
    wait_done(cyc);
    check("div_res", bus.result, 32'hFFFF_FFFD);
    issue(FMod, -32'sd7, 32'd2);
    wait_done(cyc);
    check("mod_res", bus.result, 32'hFFFF_FFFF);
    issue(FDiv, 32'd9, 32'd0);
    wait_done(cyc);
    check("div0_res", bus.result, 32'hFFFF_FFFF);
    check("div0_lat", 32'(cyc), 32'd33);
    issue(FMod, 32'd9, 32'd0);
    wait_done(cyc);
    check("mod0_res", bus.result, 32'd9);
    issue(FDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("ovf_res", bus.result, 32'h8000_0000);

    // Start ignored while busy, then flush aborts with no done.
    issue(FDiv, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    fl[FAdd]  = 1'b1;
    bus.op_a  = 32'd1;
    bus.op_b  = 32'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fl        = '0;
    check("ign_done", 32'(bus.done), 32'd0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_res",  bus.result, 32'h8000_0000);
    repeat (40) @(negedge clk);

    // Reset in the middle of a multiply.
    issue(FMul, 32'd123, 32'd456);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy),    32'd0);
    check("mrst_done", 32'(bus.done),    32'd0);
    check("mrst_res",  bus.result,       32'd0);
    check("mrst_fe",   32'(bus.flag_e),  32'd0);
    check("mrst_fgt",  32'(bus.flag_gt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(FAsr, 32'h8000_0000, 32'd4);
    check("asr_res", bus.result, 32'hF800_0000);

    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom % 10) < 6;
      bus.flush = ($urandom % 40) == 0;
      fl        = rand_flags();
      bus.op_a  = rand_opnd();
      bus.op_b  = rand_opnd();
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    fl        = '0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_alu_seq.md
# ex_alu_seq

Execute-stage ALU of the SimpleRISC pipeline. It sits directly downstream of the control unit and consumes that unit's one-hot operation flags (isAdd … isMov, isCmp) together with the two operands from operand fetch. Add, sub, compare, logic, shift and move complete in one cycle. Mul, div and mod run on an iterative 32-step engine behind a start/busy/done handshake, so the pipeline stalls while busy is high.

## Interface
- XLEN, 32: operand and result width.
- ITER, 32: iteration count for mul/div/mod; must equal XLEN.

Ports (clock and reset first):
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  operation request; sampled only when busy=0.
- flush  in  1  synchronous abort of any in-flight operation.
- isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov  in  1 each  operation flags from the control unit.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate).
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result is valid.
- result  out  XLEN  registered result; holds until the next done.
- flag_e  out  1  compare equal.
- flag_gt  out  1  compare signed greater-than.

## Operation
- Reset values: busy=0, done=0, result=0, flag_e=0, flag_gt=0, FSM in IDLE.
- Flag priority when more than one flag is set (first match wins): Mul, Div, Mod, Add, Sub, Cmp, And, Or, Not, Mov, Lsl, Lsr, Asr.
- No flag set: result=0, done still pulses. This covers nop and the branch pass-through.
- Single-cycle results:
  - add: a+b. sub: a−b. Both mod 2^32.
  - and: a&b. or: a|b. not: ~b. mov: b.
  - lsl, lsr, asr: shift a by b[4:0].
  - cmp: result=a−b, and flag_e/flag_gt are written. flag_e and flag_gt change only on cmp.
- FSM states: IDLE → ITER → FIX → IDLE.
  - IDLE: start with Mul/Div/Mod loads the engine and enters ITER. start with any other flag writes the result and pulses done, staying in IDLE.
  - ITER: 32 steps, counter 31 down to 0. On 0, go to FIX.
  - FIX: sign correction; write result, pulse done, return to IDLE.
- Arithmetic is signed two's complement on operand magnitudes, with the sign applied in FIX:
  - mul: low 32 bits of the product.
  - div: quotient truncates toward zero.
  - mod: remainder takes the sign of the dividend.
- Boundary cases:
  - div by 0: quotient 0xFFFFFFFF. mod by 0: result = a.
  - 0x80000000 / −1: quotient 0x80000000. mod: 0.
  - The divide-by-zero and overflow results still take the full latency.
- start while busy=1 is ignored; the upstream stage must hold it.
- flush in any state: back to IDLE, busy=0, no done, result and flags unchanged. flush together with start in IDLE: flush wins and nothing is accepted.
- rst_n low mid-operation: immediate return to reset values.

## Timing
- Single-cycle op accepted at edge E0: done=1 and result valid for the cycle after E0. busy stays 0.
- Multi-cycle op accepted at E0:
  - busy=1 from E0 until E33.
  - done=1 and result valid for the cycle after E33. busy=0 in that same cycle.
  - Latency is 33 cycles.
- A new start is accepted in the same cycle done is high (back-to-back operation).
- Operands and flags are captured at E0. Later changes have no effect.

## Structure
- Package alu_pkg holds:
  - XLEN and ITER.
  - FSM state enum (IDLE, ITER, FIX).
  - Internal op-select enum produced by the priority encoder.
  - DIV0_QUOT constant (all ones).
- One sub-module, seq_muldiv. It contains the shift-add multiplier, the restoring divider, the iteration counter and the sign fixup, with its own start/done handshake.
- ex_alu_seq contains the priority encoder, the single-cycle datapath, the top FSM and the output registers.

## Test plan
- isAdd, a=7, b=−3, start → done one cycle later with result=4, busy never high. Then isCmp, a=5, b=5 → flag_e=1, flag_gt=0, result=0.
- isMul, a=−6, b=7, start → busy high for 33 cycles, then one done pulse with result=0xFFFFFFD6 (−42).
- isDiv, a=−7, b=2 → result=0xFFFFFFFD (−3). isMod with the same operands → result=0xFFFFFFFF (−1).
- isDiv, b=0, a=9 → result=0xFFFFFFFF. isMod, b=0 → result=9. isDiv, a=0x80000000, b=−1 → result=0x80000000.
- Start a div, assert start with isAdd at cycle 10 → ignored. Assert flush at cycle 20 → busy drops next cycle, no done, result unchanged.
- Start a mul, pull rst_n low mid-ITER → all outputs at reset values immediately. After release, isAsr with a=0x80000000, b=4 → result=0xF8000000.
